// File: rtl/chest_pkg.sv
// Shared constants and types for the Chest algorithm dispatcher.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package chest_pkg;

  localparam int ALGO_W    = 6;
  localparam int NUM_ALGOS = 50;

  // Select value presented to the framework when no algorithm is active.
  localparam logic [ALGO_W-1:0] PARK_SEL   = 6'd63;
  // First invalid algorithm ID, in select width for direct comparison.
  localparam logic [ALGO_W-1:0] ALGO_LIMIT = ALGO_W'(NUM_ALGOS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } dispatch_state_t;

  // True when the framework actually implements this algorithm ID.
  function automatic logic is_valid_algo(input logic [ALGO_W-1:0] id);
    return id < ALGO_LIMIT;
  endfunction

endpackage

// File: rtl/chest_req_fifo.sv
// Synchronous request FIFO holding pending algorithm IDs.
// Latency: a pushed entry is visible at head the cycle after the push (no bypass).
// Backpressure: push ignored while full; pop ignored while empty.
module chest_req_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Extra MSB on each pointer distinguishes full from empty when indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  // Storage write; contents need no reset since empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_dat;
    end
  end

  // Pointer update; wrapping falls out of the natural binary rollover.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/chest_algo_dispatcher.sv
// Queues algorithm requests and runs them one at a time on the Chest framework.
// Latency: valid ID done 4 cycles after push (framework answering next cycle); invalid ID 2 cycles.
// Backpressure: req_ready drops when the queue is full; done_valid cannot be stalled.
// Optional CHEST_DISPATCH_STATS_EN adds saturating ok/error completion counters.
module chest_algo_dispatcher
  import chest_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ALGO_W-1:0] req_algo,
  output logic              req_ready,
  output logic [ALGO_W-1:0] algo_select,
  input  logic              algo_ready,
  output logic              done_valid,
  output logic [ALGO_W-1:0] done_algo,
  output logic              done_error,
  output logic              busy
`ifdef CHEST_DISPATCH_STATS_EN
  ,
  output logic [15:0]       stat_ok_cnt,
  output logic [15:0]       stat_err_cnt
`endif
);

  localparam int            TW        = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

  dispatch_state_t   state;
  dispatch_state_t   state_nxt;
  logic [ALGO_W-1:0] cur_id;
  logic [ALGO_W-1:0] cur_nxt;
  logic [ALGO_W-1:0] sel_nxt;
  logic [TW-1:0]     timer;
  logic [TW-1:0]     timer_nxt;
  logic              fin_err;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ALGO_W-1:0] fifo_head;

  assign req_ready = !fifo_full;
  assign busy      = (state != IDLE) || !fifo_empty;

  chest_req_fifo #(
    .WIDTH (ALGO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (req_valid && req_ready),
    .push_dat (req_algo),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and datapath steering; fin_err is the error flag reported on entry to DONE.
  always_comb begin
    state_nxt = state;
    cur_nxt   = cur_id;
    sel_nxt   = algo_select;
    timer_nxt = timer;
    fin_err   = 1'b0;
    fifo_pop  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cur_nxt  = fifo_head;
          if (is_valid_algo(fifo_head)) begin
            sel_nxt   = fifo_head;
            state_nxt = ISSUE;
          end else begin
            // Unknown ID never reaches the framework; select stays parked.
            fin_err   = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      ISSUE: begin
        // algo_ready still reflects the previous select here, so it is not looked at.
        timer_nxt = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (algo_ready) begin
          state_nxt = DONE;
        end else if (timer == TIMER_MAX) begin
          fin_err   = 1'b1;
          state_nxt = DONE;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      DONE: begin
        sel_nxt   = PARK_SEL;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered datapath and completion outputs; done_* are loaded as DONE is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_id      <= '0;
      algo_select <= PARK_SEL;
      timer       <= '0;
      done_valid  <= 1'b0;
      done_algo   <= '0;
      done_error  <= 1'b0;
    end else begin
      cur_id      <= cur_nxt;
      algo_select <= sel_nxt;
      timer       <= timer_nxt;
      done_valid  <= (state_nxt == DONE);
      if (state_nxt == DONE) begin
        done_algo  <= cur_nxt;
        done_error <= fin_err;
      end
    end
  end

`ifdef CHEST_DISPATCH_STATS_EN
  // Saturating completion counters, bumped once per done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ok_cnt  <= '0;
      stat_err_cnt <= '0;
    end else if (done_valid) begin
      if (!done_error && stat_ok_cnt != 16'hFFFF)  stat_ok_cnt  <= stat_ok_cnt + 16'd1;
      if (done_error  && stat_err_cnt != 16'hFFFF) stat_err_cnt <= stat_err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_chest_algo_dispatcher.sv
// Bench for chest_algo_dispatcher paired with a registered framework model.
// Directed vectors with hand-computed cycle offsets relative to the push cycle.
module tb_chest_algo_dispatcher;
  import chest_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [5:0] req_algo;
  logic       req_ready;
  logic [5:0] algo_select;
  logic       algo_ready = 1'b0;
  logic       done_valid;
  logic [5:0] done_algo;
  logic       done_error;
  logic       busy;
  logic       model_en;
`ifdef CHEST_DISPATCH_STATS_EN
  logic [15:0] stat_ok_cnt;
  logic [15:0] stat_err_cnt;
`endif

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  int mon_id[$];
  int mon_err[$];
  int mon_cyc[$];

  chest_algo_dispatcher dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_algo    (req_algo),
    .req_ready   (req_ready),
    .algo_select (algo_select),
    .algo_ready  (algo_ready),
    .done_valid  (done_valid),
    .done_algo   (done_algo),
    .done_error  (done_error),
    .busy        (busy)
`ifdef CHEST_DISPATCH_STATS_EN
    ,
    .stat_ok_cnt (stat_ok_cnt),
    .stat_err_cnt(stat_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Framework model: ready is registered and high only for an implemented select.
  always @(posedge clk) algo_ready <= (rst === 1'b0) && model_en && (algo_select < 6'd50);

  // Completion monitor.
  always @(negedge clk) begin
    if (rst === 1'b0 && done_valid === 1'b1) begin
      mon_id.push_back(int'(done_algo));
      mon_err.push_back(int'(done_error));
      mon_cyc.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present one request and hold it until accepted; reports accept cycle and stall count.
  task automatic push(input logic [5:0] id, output int acc_cyc, output int stalls);
    stalls = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_algo  = id;
    while (!req_ready && stalls < 50) begin
      stalls++;
      @(negedge clk);
    end
    acc_cyc = cyc;
    @(posedge clk);
  endtask

  typedef struct {
    logic [5:0] id;
    logic       err;
    int         lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int t, st, base, s, t8, st8, waited, dcyc;
    int exp_ids[6];

    vecs[0] = '{id: 6'd7,  err: 1'b0, lat: 4};
    vecs[1] = '{id: 6'd55, err: 1'b1, lat: 2};
    vecs[2] = '{id: 6'd0,  err: 1'b0, lat: 4};
    vecs[3] = '{id: 6'd49, err: 1'b0, lat: 4};
    vecs[4] = '{id: 6'd50, err: 1'b1, lat: 2};
    vecs[5] = '{id: 6'd63, err: 1'b1, lat: 2};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_algo  = 6'd0;
    model_en  = 1'b1;

    // Reset held two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_select",     algo_select, 63);
    chk("reset_done_valid", done_valid,  0);
    chk("reset_done_algo",  done_algo,   0);
    chk("reset_done_error", done_error,  0);
    chk("reset_busy",       busy,        0);
    chk("reset_req_ready",  req_ready,   1);

    // Single requests on an idle dispatcher, checked cycle by cycle.
    for (int i = 0; i < 6; i++) begin
      push(vecs[i].id, t, st);
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        req_valid = 1'b0;
        chk("vec_cycle_align", cyc - t, k);
        chk($sformatf("vec%0d_k%0d_done_valid", i, k), done_valid, (k == vecs[i].lat));
        chk($sformatf("vec%0d_k%0d_select", i, k), algo_select,
            (!vecs[i].err && k >= 2 && k <= 4) ? int'(vecs[i].id) : 63);
        chk($sformatf("vec%0d_k%0d_busy", i, k), busy, (k <= vecs[i].lat));
        if (k == vecs[i].lat) begin
          chk($sformatf("vec%0d_done_algo", i), done_algo, vecs[i].id);
          chk($sformatf("vec%0d_done_error", i), done_error, vecs[i].err);
        end
      end
    end

    // Timeout: framework silent, WAIT entered at T+3, gives up TIMEOUT cycles later.
    @(negedge clk);
    model_en = 1'b0;
    push(6'd3, t, st);
    waited = 0;
    dcyc   = -1;
    while (waited < 40 && dcyc < 0) begin
      @(negedge clk);
      req_valid = 1'b0;
      waited++;
      if (done_valid === 1'b1) begin
        dcyc = cyc;
        chk("timeout_done_algo",  done_algo,  3);
        chk("timeout_done_error", done_error, 1);
      end
    end
    chk("timeout_latency", dcyc - t, 19);
    @(negedge clk);
    model_en = 1'b1;
    chk("timeout_select_parked", algo_select, 63);

    // Queue fill: 1 then 4..7 back-to-back fill the queue, 8 is held one cycle.
    base = mon_id.size();
    push(6'd1, s, st);
    for (int v = 4; v <= 7; v++) begin
      push(6'(v), t, st);
      chk($sformatf("fill_push%0d_stalls", v), st, 0);
    end
    push(6'd8, t8, st8);
    chk("fill_push8_stalls", st8, 1);
    chk("fill_push8_accept", t8 - s, 6);
    @(negedge clk);
    req_valid = 1'b0;
    waited = 0;
    while (waited < 60 && mon_id.size() < base + 6) begin
      @(negedge clk);
      waited++;
    end
    chk("fill_done_count", mon_id.size() - base, 6);
    exp_ids = '{1, 4, 5, 6, 7, 8};
    for (int j = 0; j < 6; j++) begin
      if (base + j < mon_id.size()) begin
        chk($sformatf("fill_done%0d_id", j),  mon_id[base + j],  exp_ids[j]);
        chk($sformatf("fill_done%0d_err", j), mon_err[base + j], 0);
        chk($sformatf("fill_done%0d_cyc", j), mon_cyc[base + j] - s, 4 * (j + 1));
      end
    end
    repeat (3) @(negedge clk);
    chk("fill_no_extra_done", mon_id.size() - base, 6);

`ifdef CHEST_DISPATCH_STATS_EN
    chk("stats_ok_before_rst",  stat_ok_cnt,  9);
    chk("stats_err_before_rst", stat_err_cnt, 4);
`endif

    // Reset during WAIT for ID 10 with ID 11 still queued.
    @(negedge clk);
    model_en = 1'b0;
    base = mon_id.size();
    push(6'd10, t, st);
    push(6'd11, t, st);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_pre_select", algo_select, 10);
    chk("abort_pre_busy",   busy,        1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_select",     algo_select, 63);
    chk("abort_busy",       busy,        0);
    chk("abort_req_ready",  req_ready,   1);
    chk("abort_done_valid", done_valid,  0);
`ifdef CHEST_DISPATCH_STATS_EN
    chk("abort_stat_ok",  stat_ok_cnt,  0);
    chk("abort_stat_err", stat_err_cnt, 0);
`endif
    model_en = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_no_done", mon_id.size() - base, 0);
    chk("abort_idle_busy", busy, 0);
    chk("abort_idle_select", algo_select, 63);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
